// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion controller and the sprite renderer.
package sprite_motion_ctrl_pkg;

  // Sprite bitmap edge length in pixels, shared with the renderer.
  localparam int unsigned SPRITE_SIZE = 16;

  // Per-frame update sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUpdX = 2'd1,
    StUpdY = 2'd2
  } motion_state_e;

  // -8 cannot be negated in 4 bits, so it is stored as -7.
  function automatic logic [3:0] sat_vel(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b1001 : v;
  endfunction

  // Clamp a loaded coordinate into [lo, hi].
  function automatic logic [7:0] clamp_pos(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    logic [7:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis position step: add signed velocity, clamp at the limits and
// reflect the velocity when an edge is hit.
module axis_step #(
  parameter logic [7:0] Lo = 8'd0,
  parameter logic [7:0] Hi = 8'd240
) (
  input  logic [7:0] pos_i,
  input  logic [3:0] vel_i,
  output logic [7:0] next_pos_o,
  output logic [3:0] next_vel_o,
  output logic       bounce_o
);

  logic [8:0] nx;

  // 9-bit sum so that underflow below zero shows up in nx[8].
  assign nx = {1'b0, pos_i} + {{5{vel_i[3]}}, vel_i};

  // Clamp/reflect decision; zero velocity and an exact landing on a limit never bounce.
  always_comb begin
    next_pos_o = nx[7:0];
    next_vel_o = vel_i;
    bounce_o   = 1'b0;
    if (!vel_i[3] && (vel_i != 4'd0)) begin
      if (nx > {1'b0, Hi}) begin
        next_pos_o = Hi;
        next_vel_o = 4'd0 - vel_i;
        bounce_o   = 1'b1;
      end
    end else if (vel_i[3]) begin
      if (nx[8] || (nx < {1'b0, Lo})) begin
        next_pos_o = Lo;
        next_vel_o = 4'd0 - vel_i;
        bounce_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: keeps sprite position/velocity, steps the position
// once per frame on the vsync rising edge, and produces renderer strobes.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter logic [7:0] X_MIN = 8'd0,
  parameter logic [7:0] X_MAX = 8'd240,
  parameter logic [7:0] Y_MIN = 8'd0,
  parameter logic [7:0] Y_MAX = 8'd224
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       pos_load,
  input  logic [7:0] pos_x_in,
  input  logic [7:0] pos_y_in,
  input  logic       vel_load,
  input  logic [3:0] vel_x_in,
  input  logic [3:0] vel_y_in,
  output logic [7:0] sprite_x,
  output logic [7:0] sprite_y,
  output logic       vstart,
  output logic       hstart,
  output logic       load,
  output logic       bounce_x,
  output logic       bounce_y
);

  motion_state_e state_q;
  logic [7:0]    sprite_x_q, sprite_y_q;
  logic [3:0]    vel_x_q, vel_y_q;
  logic          bounce_x_q, bounce_y_q;
  logic          vsync_q, vstart_q, hstart_q, load_q;
  logic          vsync_rise;

  logic [7:0]    x_next, y_next;
  logic [3:0]    vx_next, vy_next;
  logic          x_bounce, y_bounce;

  assign vsync_rise = vsync & ~vsync_q;

  axis_step #(
    .Lo (X_MIN),
    .Hi (X_MAX)
  ) u_step_x (
    .pos_i      (sprite_x_q),
    .vel_i      (vel_x_q),
    .next_pos_o (x_next),
    .next_vel_o (vx_next),
    .bounce_o   (x_bounce)
  );

  axis_step #(
    .Lo (Y_MIN),
    .Hi (Y_MAX)
  ) u_step_y (
    .pos_i      (sprite_y_q),
    .vel_i      (vel_y_q),
    .next_pos_o (y_next),
    .next_vel_o (vy_next),
    .bounce_o   (y_bounce)
  );

  // Per-frame update FSM with position/velocity state and bounce pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sprite_x_q <= X_MIN;
      sprite_y_q <= Y_MIN;
      vel_x_q    <= 4'd0;
      vel_y_q    <= 4'd0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
    end else begin
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (vsync_rise) state_q <= StUpdX;
        end
        StUpdX: begin
          state_q    <= StUpdY;
          sprite_x_q <= x_next;
          vel_x_q    <= vx_next;
          bounce_x_q <= x_bounce;
        end
        StUpdY: begin
          state_q    <= StIdle;
          sprite_y_q <= y_next;
          vel_y_q    <= vy_next;
          bounce_y_q <= y_bounce;
        end
        default: state_q <= StIdle;
      endcase
      // Host loads are applied last so they override any step in this cycle.
      if (pos_load) begin
        sprite_x_q <= clamp_pos(pos_x_in, X_MIN, X_MAX);
        sprite_y_q <= clamp_pos(pos_y_in, Y_MIN, Y_MAX);
      end
      if (vel_load) begin
        vel_x_q <= sat_vel(vel_x_in);
        vel_y_q <= sat_vel(vel_y_in);
      end
    end
  end

  // Renderer strobes and vsync edge register, all one clock behind the beam.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      vstart_q <= 1'b0;
      hstart_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      vstart_q <= (vpos == {1'b0, sprite_y_q}) && (hpos == 9'd0);
      hstart_q <= (hpos == {1'b0, sprite_x_q});
      load_q   <= hsync;
    end
  end

  assign sprite_x = sprite_x_q;
  assign sprite_y = sprite_y_q;
  assign vstart   = vstart_q;
  assign hstart   = hstart_q;
  assign load     = load_q;
  assign bounce_x = bounce_x_q;
  assign bounce_y = bounce_y_q;

endmodule
